dom3_share_feeder: RTL and testbench
====================================

Name: dom3_share_feeder

Overview:
- Upstream companion of the 4-share (d=3) DOM AND gadget.
- Accepts one unmasked bit pair (a, b) per transaction over a valid/ready handshake.
- Splits each bit into 4 Boolean shares using an internal seeded PRNG. Emits the 4-bit a/b share vectors plus the 6 fresh refreshing bits the gadget consumes, all from one registered output stage.
- Every transaction consumes exactly one PRNG step, so sequences are reproducible for leakage evaluation.

Parameters:
- WARMUP_CYCLES, 16, number of PRNG steps discarded after each seed load before RUN (0 allowed).
- SEED_DEFAULT, 32'h0000_0001, PRNG state after reset.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- seed_valid  input  1  load seed this cycle
- seed  input  32  PRNG seed; 0 is replaced by 32'h1
- in_valid  input  1  unmasked operand pair valid
- in_ready  output  1  feeder accepts in_a/in_b this cycle
- in_a  input  1  unmasked bit a
- in_b  input  1  unmasked bit b
- out_valid  output  1  shares/refreshing valid
- out_ready  input  1  downstream accepts output
- a_sh  output  4  shares of a; XOR of all 4 bits = in_a
- b_sh  output  4  shares of b; XOR of all 4 bits = in_b
- refreshing  output  6  fresh randomness for the gadget's cross terms
- busy  output  1  high in UNSEEDED or WARMUP

Behaviour:
- Reset (async, rst=1):
  - state=UNSEEDED, prng=SEED_DEFAULT, warm counter=0.
  - out_valid=0, a_sh=0, b_sh=0, refreshing=0.
  - busy=1, in_ready=0.
- PRNG step function next(x), xorshift32 applied in order:
  - x ^= x<<13
  - x ^= x>>17
  - x ^= x<<5
  - All shifts are 32-bit logical.
- States:
  - UNSEEDED: waits for seed_valid.
  - WARMUP: prng <= next(prng) every cycle. Counter runs 0..WARMUP_CYCLES-1, then the FSM goes to RUN. With WARMUP_CYCLES=0, the cycle after the seed load is RUN.
  - RUN: accepts transactions.
- seed_valid:
  - Sampled in any state and has priority over everything else.
  - prng <= (seed==0 ? 32'h1 : seed), counter <= 0, state <= WARMUP (or RUN if WARMUP_CYCLES=0).
  - out_valid <= 0; any pending output is discarded.
- in_ready = (state==RUN) && !seed_valid && (!out_valid || out_ready). This is combinational.
- Accept = in_valid && in_ready. On accept:
  - n = next(prng); prng <= n; r = n[11:0].
  - a_sh[3:1] <= r[2:0]; a_sh[0] <= in_a ^ r[0] ^ r[1] ^ r[2].
  - b_sh[3:1] <= r[5:3]; b_sh[0] <= in_b ^ r[3] ^ r[4] ^ r[5].
  - refreshing <= r[11:6]; out_valid <= 1.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 transaction/cycle while out_ready=1.
- out_valid && out_ready with no accept in the same cycle: out_valid <= 0. Data registers hold their last value.
- out_valid && !out_ready: a_sh, b_sh and refreshing stay stable and in_ready=0. The PRNG does not step.
- The PRNG steps only on accept or in WARMUP. There are no idle steps.
- Unmasked values never appear on any output or internal register other than XOR-combined into share 0.
- busy = (state != RUN).

Test Plan:
- Reset then idle 10 cycles -> out_valid=0, in_ready=0, busy=1, all data outputs 0.
- WARMUP_CYCLES=0, seed=32'h1, then one transaction in_a=1, in_b=1 -> next cycle out_valid=1, a_sh=4'b0010, b_sh=4'b1000, refreshing=6'b000000; prng=32'h0004_2021.
- Seed=0 with WARMUP_CYCLES=0 -> results identical to seed=1 (zero-seed substitution).
- Default WARMUP_CYCLES=16, seed load -> busy=1 and in_ready=0 for exactly 16 cycles; first transaction shares equal a reference model stepped 17 times.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, in_ready=0, PRNG unchanged; release -> back-to-back accepts, 1/cycle.
- Random 10k transactions with a golden model -> XOR(a_sh)=in_a, XOR(b_sh)=in_b, bit-exact shares; seed_valid asserted mid-stream with in_valid=1 -> no accept that cycle, out_valid drops, WARMUP restarts.

Source files
------------

// File: rtl/dom3_share_feeder.sv
// dom3_share_feeder
//   Feeds the 4-share (d=3) DOM AND gadget. Takes one unmasked (a, b) bit
//   pair per valid/ready transaction and splits each bit into 4 Boolean
//   shares using an internal xorshift32 PRNG. The PRNG also supplies the 6
//   refreshing bits the gadget needs. All outputs come from one register
//   stage. The PRNG steps exactly once per accepted transaction and once
//   per warm-up cycle, so runs are reproducible from the seed.
//
// Ports
//   clk, rst               clock, async active-high reset
//   seed_valid, seed       load PRNG seed (0 -> 1); overrides everything
//   in_valid/in_ready      input handshake; in_a, in_b unmasked operands
//   out_valid/out_ready    output handshake
//   a_sh, b_sh             4 shares each; XOR of the shares = operand
//   refreshing             6 fresh random bits for the gadget cross terms
//   busy                   high until seeded and warmed up
module dom3_share_feeder #(
  parameter int          WARMUP_CYCLES = 16,
  parameter logic [31:0] SEED_DEFAULT  = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  input  logic [31:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_a,
  input  logic        in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  a_sh,
  output logic [3:0]  b_sh,
  output logic [5:0]  refreshing,
  output logic        busy
);

  typedef enum logic [1:0] {UNSEEDED, WARMUP, RUN} state_t;

  localparam int          CW    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [CW-1:0] WLAST = CW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   prng_q;
  logic [31:0]   prng_nxt;
  logic [CW-1:0] warm_q;
  logic          accept;

  assign prng_nxt = xs32(prng_q);
  assign busy     = (state_q != RUN);
  // Seed load wins over an accept in the same cycle; a stalled output
  // blocks new input so the PRNG never steps without a consumer.
  assign in_ready = (state_q == RUN) && !seed_valid && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= UNSEEDED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (seed_valid)
      state_d = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
    else if (state_q == WARMUP && warm_q == WLAST)
      state_d = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prng_q     <= SEED_DEFAULT;
      warm_q     <= '0;
      out_valid  <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      refreshing <= '0;
    end else if (seed_valid) begin
      prng_q    <= (seed == 32'h0) ? 32'h1 : seed;
      warm_q    <= '0;
      out_valid <= 1'b0;
    end else if (state_q == WARMUP) begin
      prng_q <= prng_nxt;
      warm_q <= warm_q + CW'(1);
    end else if (accept) begin
      prng_q <= prng_nxt;
      // Operand only ever lands XORed into share 0.
      a_sh       <= {prng_nxt[2:0], in_a ^ (^prng_nxt[2:0])};
      b_sh       <= {prng_nxt[5:3], in_b ^ (^prng_nxt[5:3])};
      refreshing <= prng_nxt[11:6];
      out_valid  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dom3_share_feeder.sv
module tb_dom3_share_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sv[2];
  logic [31:0] seed[2];
  logic        iv[2], ia[2], ib[2], ordy[2];
  logic        irdy[2], ov[2], bsy[2];
  logic [3:0]  ash[2], bsh[2];
  logic [5:0]  rfr[2];

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  dom3_share_feeder #(.WARMUP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .seed_valid(sv[0]), .seed(seed[0]),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_a(ia[0]), .in_b(ib[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .a_sh(ash[0]), .b_sh(bsh[0]),
    .refreshing(rfr[0]), .busy(bsy[0]));

  dom3_share_feeder dut1 (
    .clk(clk), .rst(rst), .seed_valid(sv[1]), .seed(seed[1]),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_a(ia[1]), .in_b(ib[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .a_sh(ash[1]), .b_sh(bsh[1]),
    .refreshing(rfr[1]), .busy(bsy[1]));

  // ---------------- reference model ----------------
  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [3:0] mk_a(input logic [31:0] p, input logic a);
    logic [31:0] n;
    n = xs(p);
    return {n[2:0], a ^ n[0] ^ n[1] ^ n[2]};
  endfunction

  function automatic logic [3:0] mk_b(input logic [31:0] p, input logic b);
    logic [31:0] n;
    n = xs(p);
    return {n[5:3], b ^ n[3] ^ n[4] ^ n[5]};
  endfunction

  function automatic logic [5:0] mk_r(input logic [31:0] p);
    logic [31:0] n;
    n = xs(p);
    return n[11:6];
  endfunction

  logic [31:0] m_prng[2];
  int          m_warm[2];   // warm-up cycles still to run
  logic        m_seeded[2], m_ov[2], m_ia[2], m_ib[2];
  logic [3:0]  m_a[2], m_b[2];
  logic [5:0]  m_r[2];
  int          m_nacc[2];

  function automatic logic m_busy(input int d);
    return !m_seeded[d] || (m_warm[d] != 0);
  endfunction

  function automatic logic m_rdy(input int d);
    return !m_busy(d) && !sv[d] && (!m_ov[d] || ordy[d]);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_prng[d] <= 32'h1; m_warm[d] <= 0; m_seeded[d] <= 1'b0; m_ov[d] <= 1'b0;
        m_a[d] <= '0; m_b[d] <= '0; m_r[d] <= '0; m_ia[d] <= 1'b0; m_ib[d] <= 1'b0;
      end else if (sv[d]) begin
        m_prng[d] <= (seed[d] == 0) ? 32'h1 : seed[d];
        m_warm[d] <= (d == 0) ? 0 : 16;
        m_seeded[d] <= 1'b1;
        m_ov[d] <= 1'b0;
      end else if (m_busy(d)) begin
        if (m_seeded[d]) begin
          m_prng[d] <= xs(m_prng[d]);
          m_warm[d] <= m_warm[d] - 1;
        end
      end else if (iv[d] && m_rdy(d)) begin
        m_prng[d] <= xs(m_prng[d]);
        m_a[d] <= mk_a(m_prng[d], ia[d]);
        m_b[d] <= mk_b(m_prng[d], ib[d]);
        m_r[d] <= mk_r(m_prng[d]);
        m_ia[d] <= ia[d];
        m_ib[d] <= ib[d];
        m_ov[d] <= 1'b1;
        m_nacc[d] <= m_nacc[d] + 1;
      end else if (m_ov[d] && ordy[d]) begin
        m_ov[d] <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("in_ready[%0d]", d), 32'(irdy[d]), 32'(m_rdy(d)));
      chk($sformatf("busy[%0d]", d), 32'(bsy[d]), 32'(m_busy(d)));
      chk($sformatf("out_valid[%0d]", d), 32'(ov[d]), 32'(m_ov[d]));
      chk($sformatf("a_sh[%0d]", d), 32'(ash[d]), 32'(m_a[d]));
      chk($sformatf("b_sh[%0d]", d), 32'(bsh[d]), 32'(m_b[d]));
      chk($sformatf("refreshing[%0d]", d), 32'(rfr[d]), 32'(m_r[d]));
      if (m_ov[d]) begin
        chk($sformatf("xor_a[%0d]", d), 32'(^ash[d]), 32'(m_ia[d]));
        chk($sformatf("xor_b[%0d]", d), 32'(^bsh[d]), 32'(m_ib[d]));
      end
    end
  endtask

  // Inputs are set just after a falling edge; compare, then advance one cycle.
  task automatic tick();
    #1 cmp_all();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] s;
    logic        a, b;
    logic [3:0]  ea, eb;
    logic [5:0]  er;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [31:0] p;
    logic [3:0]  sa, sb;
    logic [5:0]  sr;
    int          cnt, cyc;

    // next(1) = 32'h0004_2021 -> r = 12'h021
    vt[0] = '{32'h1, 1'b1, 1'b1, 4'b0010, 4'b1000, 6'h00};
    vt[1] = '{32'h0, 1'b1, 1'b1, 4'b0010, 4'b1000, 6'h00};
    vt[2] = '{32'h1, 1'b0, 1'b0, 4'b0011, 4'b1001, 6'h00};
    vt[3] = '{32'h0, 1'b1, 1'b0, 4'b0010, 4'b1001, 6'h00};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sv[d] = 0; seed[d] = 0; iv[d] = 0; ia[d] = 0; ib[d] = 0; ordy[d] = 0;
      m_nacc[d] = 0;
    end
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("reset_busy", 32'(bsy[1]), 32'd1);
    chk("reset_in_ready", 32'(irdy[1]), 32'd0);
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_data", {ash[0], bsh[0], rfr[0]}, 32'd0);

    // Table: WARMUP_CYCLES=0, seed then one transaction.
    for (int i = 0; i < 4; i++) begin
      sv[0] = 1; seed[0] = vt[i].s; ordy[0] = 1;
      tick();
      sv[0] = 0; iv[0] = 1; ia[0] = vt[i].a; ib[0] = vt[i].b;
      tick();
      iv[0] = 0;
      #1;
      chk($sformatf("vec%0d_out_valid", i), 32'(ov[0]), 32'd1);
      chk($sformatf("vec%0d_a_sh", i), 32'(ash[0]), 32'(vt[i].ea));
      chk($sformatf("vec%0d_b_sh", i), 32'(bsh[0]), 32'(vt[i].eb));
      chk($sformatf("vec%0d_refreshing", i), 32'(rfr[0]), 32'(vt[i].er));
      tick();
    end

    // Warm-up length with default WARMUP_CYCLES=16.
    sv[1] = 1; seed[1] = 32'hDEAD_BEEF; ordy[1] = 1;
    tick();
    sv[1] = 0; iv[1] = 1; ia[1] = 1; ib[1] = 0;
    cnt = 0;
    while (bsy[1] && cnt < 100) begin
      chk("warm_in_ready", 32'(irdy[1]), 32'd0);
      cnt++;
      tick();
    end
    chk("warm_cycles", cnt, 32'd16);
    tick();   // accept
    iv[1] = 0;
    p = 32'hDEAD_BEEF;
    repeat (17) p = xs(p);
    #1;
    chk("first_a_sh", 32'(ash[1]), 32'({p[2:0], 1'b1 ^ p[0] ^ p[1] ^ p[2]}));
    chk("first_b_sh", 32'(bsh[1]), 32'({p[5:3], 1'b0 ^ p[3] ^ p[4] ^ p[5]}));
    chk("first_refreshing", 32'(rfr[1]), 32'(p[11:6]));
    tick();

    // Backpressure: hold out_ready low, then release for back-to-back.
    ordy[1] = 0; iv[1] = 1; ia[1] = 0; ib[1] = 1;
    tick();
    sa = ash[1]; sb = bsh[1]; sr = rfr[1];
    for (int k = 0; k < 5; k++) begin
      ia[1] = 1'($urandom); ib[1] = 1'($urandom);
      tick();
      chk("bp_in_ready", 32'(irdy[1]), 32'd0);
      chk("bp_stable", {ash[1], bsh[1], rfr[1]}, {sa, sb, sr});
    end
    ordy[1] = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("b2b_in_ready", 32'(irdy[1]), 32'd1);
      tick();
      chk("b2b_out_valid", 32'(ov[1]), 32'd1);
    end

    // Seed load mid-stream with in_valid high.
    sv[1] = 1; seed[1] = 32'h5;
    #1 chk("seed_blocks_accept", 32'(irdy[1]), 32'd0);
    tick();
    sv[1] = 0;
    chk("seed_drops_out_valid", 32'(ov[1]), 32'd0);
    chk("seed_restarts_warmup", 32'(bsy[1]), 32'd1);

    // Randomized traffic on both instances against the model.
    cyc = 0;
    while (m_nacc[1] < 10000 && cyc < 40000) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]   = ($urandom % 4) != 0;
        ordy[d] = ($urandom % 4) != 0;
        ia[d]   = 1'($urandom);
        ib[d]   = 1'($urandom);
        sv[d]   = ($urandom % 600) == 0;
        seed[d] = (($urandom % 8) == 0) ? 32'h0 : $urandom;
      end
      tick();
      cyc++;
    end
    chk("random_accept_count_reached", 32'(m_nacc[1] >= 10000), 32'd1);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
